// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// Accepts one operation at a time, presents it to the ALU for one cycle and holds the response until retired.
module alu_arbiter #(
    parameter int   WIDTH   = 32,
    parameter logic RR_INIT = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [1:0]       i_req_valid,
    output logic [1:0]       o_req_ready,
    input  logic [2:0]       i_req0_op,
    input  logic [2:0]       i_req1_op,
    input  logic [WIDTH-1:0] i_req0_a,
    input  logic [WIDTH-1:0] i_req0_b,
    input  logic [WIDTH-1:0] i_req1_a,
    input  logic [WIDTH-1:0] i_req1_b,
    output logic [2:0]       o_alu_op,
    output logic [WIDTH-1:0] o_alu_a,
    output logic [WIDTH-1:0] o_alu_b,
    input  logic             i_alu_valid,
    input  logic [WIDTH-1:0] i_alu_result,
    output logic             o_rsp_valid,
    output logic             o_rsp_id,
    output logic             o_rsp_err,
    output logic [WIDTH-1:0] o_rsp_result,
    input  logic             i_rsp_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             prio_q, prio_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             id_q, id_d;
    logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
    logic             rsp_err_q, rsp_err_d;
    logic             rsp_id_q, rsp_id_d;

    logic [2:0]       req_op [2];
    logic [WIDTH-1:0] req_a  [2];
    logic [WIDTH-1:0] req_b  [2];

    logic [1:0]       grant;
    logic             accept;
    logic             gnt_id;

    assign req_op[0] = i_req0_op;
    assign req_op[1] = i_req1_op;
    assign req_a[0]  = i_req0_a;
    assign req_a[1]  = i_req1_a;
    assign req_b[0]  = i_req0_b;
    assign req_b[1]  = i_req1_b;

    // A lone requester always wins; a tie goes to the priority pointer.
    always_comb begin
        grant = 2'b00;
        case (i_req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    assign o_req_ready = ((state_q == IDLE) && !i_rst) ? grant : 2'b00;
    assign accept      = |(i_req_valid & o_req_ready);
    assign gnt_id      = o_req_ready[1];

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        op_d         = op_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        rsp_result_d = rsp_result_q;
        rsp_err_d    = rsp_err_q;
        rsp_id_d     = rsp_id_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = req_op[gnt_id];
                    a_d     = req_a[gnt_id];
                    b_d     = req_b[gnt_id];
                    id_d    = gnt_id;
                    prio_d  = ~gnt_id;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d = i_alu_result;
                rsp_err_d    = ~i_alu_valid;
                rsp_id_d     = id_q;
                state_d      = RESP;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            prio_q       <= RR_INIT;
            op_q         <= 3'd0;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            rsp_result_q <= '0;
            rsp_err_q    <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            op_q         <= op_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            rsp_result_q <= rsp_result_d;
            rsp_err_q    <= rsp_err_d;
            rsp_id_q     <= rsp_id_d;
        end
    end

    // The ALU sees the latched operation only while executing.
    assign o_alu_op     = (state_q == EXEC) ? op_q : 3'd0;
    assign o_alu_a      = (state_q == EXEC) ? a_q  : '0;
    assign o_alu_b      = (state_q == EXEC) ? b_q  : '0;

    assign o_rsp_valid  = (state_q == RESP);
    assign o_rsp_id     = rsp_id_q;
    assign o_rsp_err    = rsp_err_q;
    assign o_rsp_result = rsp_result_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and randomized bench for alu_arbiter with a behavioural ALU and arbitration model.
module tb_alu_arbiter;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         i_rst;
    logic [1:0]   i_req_valid;
    logic [1:0]   o_req_ready;
    logic [2:0]   i_req0_op, i_req1_op;
    logic [W-1:0] i_req0_a, i_req0_b, i_req1_a, i_req1_b;
    logic [2:0]   o_alu_op;
    logic [W-1:0] o_alu_a, o_alu_b;
    logic         alu_valid;
    logic [W-1:0] alu_result;
    logic         o_rsp_valid, o_rsp_id, o_rsp_err;
    logic [W-1:0] o_rsp_result;
    logic         i_rsp_ready;

    int n_tests = 0;
    int n_fail  = 0;
    bit m_prio  = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W), .RR_INIT(1'b0)) dut (
        .i_clk(clk), .i_rst(i_rst),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req0_op(i_req0_op), .i_req1_op(i_req1_op),
        .i_req0_a(i_req0_a), .i_req0_b(i_req0_b),
        .i_req1_a(i_req1_a), .i_req1_b(i_req1_b),
        .o_alu_op(o_alu_op), .o_alu_a(o_alu_a), .o_alu_b(o_alu_b),
        .i_alu_valid(alu_valid), .i_alu_result(alu_result),
        .o_rsp_valid(o_rsp_valid), .o_rsp_id(o_rsp_id), .o_rsp_err(o_rsp_err),
        .o_rsp_result(o_rsp_result), .i_rsp_ready(i_rsp_ready)
    );

    // Shared combinational ALU seen by the DUT.
    always_comb begin
        alu_valid  = 1'b0;
        alu_result = '0;
        case (o_alu_op)
            3'd1: begin alu_valid = 1'b1; alu_result = o_alu_a + o_alu_b; end
            3'd2: begin alu_valid = 1'b1; alu_result = o_alu_a - o_alu_b; end
            3'd3: begin alu_valid = 1'b1; alu_result = o_alu_a ^ o_alu_b; end
            3'd4: begin alu_valid = 1'b1; alu_result = o_alu_a & o_alu_b; end
            3'd5: begin alu_valid = 1'b1; alu_result = W'($signed(o_alu_a) >>> o_alu_b); end
            default: begin alu_valid = 1'b0; alu_result = '0; end
        endcase
    end

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // Expected response: arithmetic shift written as sign-filled logical shift.
    task automatic ref_alu(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           output logic err, output logic [W-1:0] res);
        int sh;
        err = 1'b0;
        res = '0;
        case (op)
            3'd1: res = a + b;
            3'd2: res = a - b;
            3'd3: res = a ^ b;
            3'd4: res = a & b;
            3'd5: begin
                sh  = (b >= W) ? W : int'(b);
                res = a[W-1] ? ~((~a) >> sh) : (a >> sh);
            end
            default: begin err = 1'b1; res = '0; end
        endcase
    endtask

    function automatic logic [1:0] exp_grant(input logic [1:0] v, input bit prio);
        if (v == 2'b11) return prio ? 2'b10 : 2'b01;
        return v;
    endfunction

    // One complete transaction starting at a falling edge with the DUT idle.
    task automatic txn(input logic [1:0] v,
                       input logic [2:0] op0, input logic [W-1:0] a0, input logic [W-1:0] b0,
                       input logic [2:0] op1, input logic [W-1:0] a1, input logic [W-1:0] b1,
                       input int stall);
        logic [1:0]   g;
        bit           gid;
        logic [2:0]   eop;
        logic [W-1:0] ea, eb, eres;
        logic         eerr;
        i_req_valid = v;
        i_req0_op = op0; i_req0_a = a0; i_req0_b = b0;
        i_req1_op = op1; i_req1_a = a1; i_req1_b = b1;
        i_rsp_ready = (stall == 0);
        #1;
        g = exp_grant(v, m_prio);
        check("ready_idle", o_req_ready, g);
        gid = (g == 2'b10);
        eop = gid ? op1 : op0;
        ea  = gid ? a1 : a0;
        eb  = gid ? b1 : b0;
        ref_alu(eop, ea, eb, eerr, eres);
        m_prio = ~gid;
        @(negedge clk);
        check("exec_alu_op", o_alu_op, eop);
        check("exec_alu_a", o_alu_a, ea);
        check("exec_alu_b", o_alu_b, eb);
        check("exec_ready", o_req_ready, 2'b00);
        check("exec_rsp_valid", o_rsp_valid, 1'b0);
        @(negedge clk);
        check("rsp_valid", o_rsp_valid, 1'b1);
        check("rsp_id", o_rsp_id, gid);
        check("rsp_err", o_rsp_err, eerr);
        check("rsp_result", o_rsp_result, eres);
        check("rsp_ready", o_req_ready, 2'b00);
        check("rsp_alu_op", o_alu_op, 3'd0);
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall_valid", o_rsp_valid, 1'b1);
            check("stall_result", o_rsp_result, eres);
            check("stall_id", o_rsp_id, gid);
            check("stall_ready", o_req_ready, 2'b00);
        end
        i_rsp_ready = 1'b1;
        @(negedge clk);
        check("retired", o_rsp_valid, 1'b0);
        $display("[TB] txn v=%b id=%0d op=%0d a=%h b=%h res=%h err=%0d stall=%0d",
                 v, gid, eop, ea, eb, eres, eerr, stall);
    endtask

    initial begin
        logic [2:0]   rop0, rop1;
        logic [W-1:0] ra0, rb0, ra1, rb1;
        logic [1:0]   rv;

        i_rst = 1'b1;
        i_req_valid = 2'b11;
        i_req0_op = 3'd1; i_req0_a = '0; i_req0_b = '0;
        i_req1_op = 3'd1; i_req1_a = '0; i_req1_b = '0;
        i_rsp_ready = 1'b1;
        #2;
        check("rst_ready", o_req_ready, 2'b00);
        check("rst_rsp_valid", o_rsp_valid, 1'b0);
        check("rst_rsp_result", o_rsp_result, '0);
        check("rst_alu_op", o_alu_op, 3'd0);
        @(negedge clk);
        @(negedge clk);
        i_rst = 1'b0;
        m_prio = 1'b0;

        // Tie after reset, then the other requester once the pointer moves.
        txn(2'b11, 3'd2, 32'd10, 32'd4, 3'd3, 32'h0000_00F0, 32'h0000_00FF, 0);
        txn(2'b11, 3'd2, 32'd10, 32'd4, 3'd3, 32'h0000_00F0, 32'h0000_00FF, 0);
        txn(2'b01, 3'd1, 32'd5, 32'd3, 3'd0, '0, '0, 0);
        txn(2'b10, 3'd0, '0, '0, 3'd4, 32'h0000_FF00, 32'h0000_0FF0, 5);
        txn(2'b01, 3'd0, 32'd1, 32'd1, 3'd0, '0, '0, 0);
        txn(2'b01, 3'd5, 32'h8000_0000, 32'd4, 3'd0, '0, '0, 1);
        txn(2'b01, 3'd1, 32'hFFFF_FFFF, 32'd1, 3'd0, '0, '0, 0);
        txn(2'b01, 3'd2, 32'hDEAD_BEEF, 32'h1234_5678, 3'd0, '0, '0, 0);

        // No request: nothing should start.
        i_req_valid = 2'b00;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_rsp", o_rsp_valid, 1'b0);
            check("idle_no_alu", o_alu_op, 3'd0);
        end

        // Reset while executing discards the operation.
        i_req_valid = 2'b01; i_req0_op = 3'd1; i_req0_a = 32'd7; i_req0_b = 32'd9;
        i_rsp_ready = 1'b1;
        @(negedge clk);
        check("pre_rst_exec", o_alu_op, 3'd1);
        i_rst = 1'b1;
        #1;
        check("midrst_alu_op", o_alu_op, 3'd0);
        check("midrst_alu_a", o_alu_a, '0);
        check("midrst_rsp_result", o_rsp_result, '0);
        check("midrst_rsp_valid", o_rsp_valid, 1'b0);
        check("midrst_ready", o_req_ready, 2'b00);
        m_prio = 1'b0;
        i_req_valid = 2'b00;
        @(negedge clk);
        i_rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("postrst_no_rsp", o_rsp_valid, 1'b0);
        end
        $display("[TB] mid-exec reset applied and released");

        for (int t = 0; t < 40; t++) begin
            rv   = 2'($urandom_range(1, 3));
            rop0 = 3'($urandom_range(0, 7));
            rop1 = 3'($urandom_range(0, 7));
            ra0  = $urandom; ra1 = $urandom;
            rb0  = (rop0 == 3'd5) ? W'($urandom_range(0, 35)) : W'($urandom);
            rb1  = (rop1 == 3'd5) ? W'($urandom_range(0, 35)) : W'($urandom);
            txn(rv, rop0, ra0, rb0, rop1, ra1, rb1, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
